// File: rtl/cam_pkg.sv
// ---------------------------------------------------------------------------
// cam_pkg : camera pipeline state encodings, frame geometry and luma weights
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cam_pkg;

    typedef enum logic [1:0] {
        ST_SKIP    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DROP    = 2'd3
    } cam_state_e;

    localparam int unsigned C_H_ACTIVE = 640;
    localparam int unsigned C_V_ACTIVE = 480;

    localparam logic [7:0] C_W_R = 8'd77;
    localparam logic [7:0] C_W_G = 8'd150;
    localparam logic [7:0] C_W_B = 8'd29;

    // Bit replication keeps full-scale inputs at full scale (31 -> 255, 63 -> 255).
    function automatic logic [7:0] expand5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] v);
        return {v, v[5:4]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rgb565_to_gray.sv
// ---------------------------------------------------------------------------
// rgb565_to_gray : two-stage RGB565 -> 8-bit luma converter with valid strobe
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rgb565_to_gray
    import cam_pkg::*;
(
    input  logic        clk_out,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [15:0] pix_i,
    output logic        valid_o,
    output logic [7:0]  y_o
);

    logic        v1_q;
    logic        v2_q;
    logic [15:0] pr_q;
    logic [15:0] pg_q;
    logic [15:0] pb_q;
    logic [7:0]  y_q;
    logic [15:0] sum;

    // Weights total 256, so the 16-bit sum cannot wrap and Y never exceeds 255.
    assign sum = pr_q + pg_q + pb_q;

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            pr_q <= 16'h0000;
            pg_q <= 16'h0000;
            pb_q <= 16'h0000;
            y_q  <= 8'h00;
        end else begin
            v1_q <= valid_i;
            v2_q <= v1_q;
            if (valid_i) begin
                pr_q <= 16'(C_W_R) * 16'(expand5(pix_i[15:11]));
                pg_q <= 16'(C_W_G) * 16'(expand6(pix_i[10:5]));
                pb_q <= 16'(C_W_B) * 16'(expand5(pix_i[4:0]));
            end
            if (v1_q) begin
                y_q <= sum[15:8];
            end
        end
    end

    assign valid_o = v2_q;
    assign y_o     = y_q;

endmodule

`default_nettype wire

// File: rtl/cam_fifo_writer.sv
// ---------------------------------------------------------------------------
// cam_fifo_writer : OV7670 DVP capture, grayscale conversion, frame-aligned FIFO writes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cam_fifo_writer
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = C_H_ACTIVE,
    parameter int unsigned V_ACTIVE    = C_V_ACTIVE,
    parameter int unsigned INIT_FRAMES = 2,
    parameter bit          GRAY_OUT    = 1'b1
) (
    input  logic        clk_out,
    input  logic        rst_n,
    input  logic        cam_vsync_i,
    input  logic        cam_href_i,
    input  logic [7:0]  cam_data_i,
    input  logic        full_fifo_i,
    output logic        wr_en_o,
    output logic [15:0] dout_o,
    output logic        frame_done_o,
    output logic        overflow_o,
    output logic        line_err_o
);

    localparam int XW  = $clog2(H_ACTIVE + 1);
    localparam int YW  = $clog2(V_ACTIVE + 1);
    localparam int FCW = (INIT_FRAMES > 0) ? $clog2(INIT_FRAMES + 1) : 1;

    logic        vs_q, vs_qq, hr_q, hr_qq;
    logic [7:0]  data_q;
    logic        vs_fall, vs_rise, hr_fall;

    cam_state_e     state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           phase_q, phase_d;
    logic [7:0]     hi_q, hi_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           ovf_q, ovf_d;
    logic           done_q, done_d;
    logic           lerr_q, lerr_d;

    logic        in_valid;
    logic        in_last;
    logic [15:0] in_pix;
    logic [1:0]  last_pipe_q;
    logic        pipe_valid;
    logic [15:0] pipe_data;
    logic        capturing;
    logic        wr_fire;
    logic        pipe_blocked;

    assign vs_fall = vs_qq & ~vs_q;
    assign vs_rise = ~vs_qq & vs_q;
    assign hr_fall = hr_qq & ~hr_q;
    assign in_pix  = {hi_q, data_q};

    assign capturing    = (state_q == ST_CAPTURE);
    assign wr_fire      = pipe_valid & capturing & ~full_fifo_i;
    assign pipe_blocked = pipe_valid & capturing & full_fifo_i;

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            vs_q        <= 1'b0;
            vs_qq       <= 1'b0;
            hr_q        <= 1'b0;
            hr_qq       <= 1'b0;
            data_q      <= 8'h00;
            state_q     <= ST_SKIP;
            fcnt_q      <= '0;
            phase_q     <= 1'b0;
            hi_q        <= 8'h00;
            x_q         <= '0;
            y_q         <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            lerr_q      <= 1'b0;
            last_pipe_q <= 2'b00;
        end else begin
            vs_q        <= cam_vsync_i;
            vs_qq       <= vs_q;
            hr_q        <= cam_href_i;
            hr_qq       <= hr_q;
            data_q      <= cam_data_i;
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            x_q         <= x_d;
            y_q         <= y_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            lerr_q      <= lerr_d;
            last_pipe_q <= {last_pipe_q[0], in_valid & in_last};
        end
    end

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        phase_d  = phase_q;
        hi_d     = hi_q;
        x_d      = x_q;
        y_d      = y_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        lerr_d   = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;

        case (state_q)
            ST_SKIP: begin
                if (fcnt_q == FCW'(INIT_FRAMES)) begin
                    state_d = ST_SYNC;
                end else if (vs_fall) begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end

            ST_SYNC: begin
                if (vs_fall) begin
                    state_d = ST_CAPTURE;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end

            ST_CAPTURE: begin
                if (hr_q) begin
                    if (!phase_q) begin
                        hi_d    = data_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        // y reaching V_ACTIVE means every pixel of the frame has been issued.
                        if (y_q < YW'(V_ACTIVE)) begin
                            in_valid = 1'b1;
                            in_last  = (x_q == XW'(H_ACTIVE - 1)) && (y_q == YW'(V_ACTIVE - 1));
                            if (x_q == XW'(H_ACTIVE - 1)) begin
                                x_d = '0;
                                y_d = y_q + 1'b1;
                            end else begin
                                x_d = x_q + 1'b1;
                            end
                        end
                    end
                end else if (hr_fall) begin
                    phase_d = 1'b0;
                    if (x_q != '0) begin
                        lerr_d = 1'b1;
                        x_d    = '0;
                        if (y_q < YW'(V_ACTIVE)) begin
                            y_d = y_q + 1'b1;
                        end
                    end
                end

                // Full beats frame completion, which beats an early VSYNC rise.
                if (pipe_blocked) begin
                    state_d = ST_DROP;
                    ovf_d   = 1'b1;
                end else if (wr_fire && last_pipe_q[1]) begin
                    done_d  = 1'b1;
                    state_d = ST_SYNC;
                end else if (vs_rise) begin
                    state_d = ST_SYNC;
                end
            end

            ST_DROP: begin
                if (vs_fall) begin
                    state_d = ST_CAPTURE;
                    x_d     = '0;
                    y_d     = '0;
                    phase_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_SKIP;
            end
        endcase
    end

    generate
        if (GRAY_OUT) begin : g_gray
            logic [7:0] luma;

            rgb565_to_gray u_gray (
                .clk_out (clk_out),
                .rst_n   (rst_n),
                .valid_i (in_valid),
                .pix_i   (in_pix),
                .valid_o (pipe_valid),
                .y_o     (luma)
            );

            assign pipe_data = {8'h00, luma};
        end else begin : g_raw
            // Matches the converter latency so wr_en timing is independent of GRAY_OUT.
            logic [15:0] raw0_q;
            logic [15:0] raw1_q;
            logic [1:0]  rv_q;

            always_ff @(posedge clk_out or negedge rst_n) begin
                if (!rst_n) begin
                    raw0_q <= 16'h0000;
                    raw1_q <= 16'h0000;
                    rv_q   <= 2'b00;
                end else begin
                    if (in_valid) begin
                        raw0_q <= in_pix;
                    end
                    raw1_q <= raw0_q;
                    rv_q   <= {rv_q[0], in_valid};
                end
            end

            assign pipe_valid = rv_q[1];
            assign pipe_data  = raw1_q;
        end
    endgenerate

    assign wr_en_o      = wr_fire;
    assign dout_o       = pipe_data;
    assign frame_done_o = done_q;
    assign overflow_o   = ovf_q;
    assign line_err_o   = lerr_q;

endmodule

`default_nettype wire
